// File: rtl/main_mem_ctrl.sv
// main_mem_ctrl
//   Block-granular backing memory sitting directly below the data cache.
//   It accepts dirty-block writebacks and serves block refills. Each access
//   takes a fixed LATENCY cycles of array time.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   wb_valid/wb_addr/     writeback request (held until accepted), block data
//   wb_data/wb_ready      and the accept handshake
//   wb_done               one-cycle pulse once the block is in the array
//   rd_req/rd_addr/       refill request (held until accepted) and accept
//   rd_ready              handshake
//   rd_valid/rd_data      one-cycle refill strobe; rd_data holds afterwards
//   busy                  controller is not idle
module main_mem_ctrl #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int OFFSET_WIDTH  = 4,
  parameter int MEM_BLOCKS    = 1024,
  parameter int LATENCY       = 4
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      wb_valid,
  input  logic [ADDRESS_WIDTH-1:0]                  wb_addr,
  input  logic [DATA_WIDTH*(1<<OFFSET_WIDTH)-1:0]   wb_data,
  output logic                                      wb_ready,
  output logic                                      wb_done,
  input  logic                                      rd_req,
  input  logic [ADDRESS_WIDTH-1:0]                  rd_addr,
  output logic                                      rd_ready,
  output logic                                      rd_valid,
  output logic [DATA_WIDTH*(1<<OFFSET_WIDTH)-1:0]   rd_data,
  output logic                                      busy
);

  localparam int BYTE_OFFSET     = $clog2(DATA_WIDTH / 8);
  localparam int WORDS_PER_BLOCK = 1 << OFFSET_WIDTH;
  localparam int BLOCK_W         = DATA_WIDTH * WORDS_PER_BLOCK;
  localparam int IDX_W           = $clog2(MEM_BLOCKS);
  localparam int IDX_LSB         = OFFSET_WIDTH + BYTE_OFFSET;
  localparam int CNT_W           = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WB   = 2'd1;
  localparam logic [1:0] RD   = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]         state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [BLOCK_W-1:0] wb_data_reg;
  logic               mem_we;

  logic [BLOCK_W-1:0] mem [MEM_BLOCKS];

  logic [IDX_W-1:0] wb_idx;
  logic [IDX_W-1:0] rd_idx;

  // Word/byte offset and the bits above the index do not select anything;
  // addresses alias modulo MEM_BLOCKS.
  assign wb_idx = wb_addr[IDX_LSB +: IDX_W];
  assign rd_idx = rd_addr[IDX_LSB +: IDX_W];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{wb_addr[IDX_LSB-1:0], wb_addr[ADDRESS_WIDTH-1:IDX_LSB+IDX_W],
                              rd_addr[IDX_LSB-1:0], rd_addr[ADDRESS_WIDTH-1:IDX_LSB+IDX_W]};

  assign wb_ready = (state_reg == IDLE);
  // A pending writeback blocks the refill, so a same-block refill sees new data.
  assign rd_ready = (state_reg == IDLE) && !wb_valid;
  assign busy     = (state_reg != IDLE);

  // Gated by reset so an aborted writeback can never land in the array.
  assign mem_we = (state_reg == WB) && (cnt_reg == '0) && !reset;

  // Array write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_reg] <= wb_data_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      wb_data_reg <= '0;
      wb_done     <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
    end else begin
      wb_done  <= 1'b0;
      rd_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (wb_valid) begin
            idx_reg     <= wb_idx;
            wb_data_reg <= wb_data;
            cnt_reg     <= CNT_LOAD;
            state_reg   <= WB;
          end else if (rd_req) begin
            idx_reg   <= rd_idx;
            cnt_reg   <= CNT_LOAD;
            state_reg <= RD;
          end
        end
        WB: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else begin
            wb_done   <= 1'b1;
            state_reg <= IDLE;
          end
        end
        RD: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else begin
            rd_data   <= mem[idx_reg];
            rd_valid  <= 1'b1;
            state_reg <= RESP;
          end
        end
        default: begin
          // RESP: one turnaround cycle while the refill strobe drops.
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_main_mem_ctrl.sv
// tb_main_mem_ctrl
//   Scoreboard bench for main_mem_ctrl. It drives a LATENCY=4 instance
//   (dut0) and a LATENCY=1 instance (dut1). At each accept, the stimulus
//   pushes the expected response (kind, data, due cycle). A negedge monitor
//   pops that entry and compares it whenever wb_done or rd_valid is seen.
module tb_main_mem_ctrl;

  localparam int BW   = 512;
  localparam int LAT0 = 4;
  localparam int LAT1 = 1;

  typedef logic [BW-1:0] blk_t;
  typedef struct {
    bit   is_rd;
    blk_t data;
    int   due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // dut0 signals
  logic        wb_valid, wb_ready, wb_done, rd_req, rd_ready, rd_valid, busy;
  logic [31:0] wb_addr, rd_addr;
  blk_t        wb_data, rd_data;
  // dut1 signals
  logic        wb_valid1, wb_ready1, wb_done1, rd_req1, rd_ready1, rd_valid1, busy1;
  logic [31:0] wb_addr1, rd_addr1;
  blk_t        wb_data1, rd_data1;

  main_mem_ctrl #(.LATENCY(LAT0)) dut0 (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_ready(wb_ready), .wb_done(wb_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy)
  );

  main_mem_ctrl #(.LATENCY(LAT1)) dut1 (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid1), .wb_addr(wb_addr1), .wb_data(wb_data1),
    .wb_ready(wb_ready1), .wb_done(wb_done1),
    .rd_req(rd_req1), .rd_addr(rd_addr1), .rd_ready(rd_ready1),
    .rd_valid(rd_valid1), .rd_data(rd_data1), .busy(busy1)
  );

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   pulses0 = 0;
  exp_t q0[$];
  exp_t q1[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input blk_t act, input blk_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic blk_t mk_block(input logic [31:0] base);
    blk_t b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = base + 32'(i);
    return b;
  endfunction

  // Monitor: one line per completed transaction.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (wb_done || rd_valid) begin
        pulses0++;
        chk("dut0_single_pulse", blk_t'(wb_done && rd_valid), blk_t'(0));
        if (q0.size() == 0) begin
          chk("dut0_unexpected_resp", blk_t'(1), blk_t'(0));
        end else begin
          e = q0.pop_front();
          chk("dut0_kind", blk_t'(rd_valid), blk_t'(e.is_rd));
          chk("dut0_timing", blk_t'(cyc), blk_t'(e.due));
          if (e.is_rd) chk("dut0_rd_data", rd_data, e.data);
          $display("[TB] dut0 %s response at cycle %0d", e.is_rd ? "refill" : "writeback", cyc);
        end
      end
      if (wb_done1 || rd_valid1) begin
        if (q1.size() == 0) begin
          chk("dut1_unexpected_resp", blk_t'(1), blk_t'(0));
        end else begin
          e = q1.pop_front();
          chk("dut1_kind", blk_t'(rd_valid1), blk_t'(e.is_rd));
          chk("dut1_timing", blk_t'(cyc), blk_t'(e.due));
          if (e.is_rd) chk("dut1_rd_data", rd_data1, e.data);
          $display("[TB] dut1 %s response at cycle %0d", e.is_rd ? "refill" : "writeback", cyc);
        end
      end
    end
  end

  // dut0 transaction: optional writeback and/or refill raised together.
  task automatic xact(input bit do_wb, input logic [31:0] waddr, input blk_t wdata,
                      input bit do_rd, input logic [31:0] raddr, input blk_t rexp,
                      input bit chk_blocked);
    bit wb_p = do_wb;
    bit rd_p = do_rd;
    bit blk_chk = chk_blocked;
    int budget = 0;
    @(negedge clk);
    wb_valid = do_wb; wb_addr = waddr; wb_data = wdata;
    rd_req = do_rd; rd_addr = raddr;
    while ((wb_p || rd_p) && budget < 50) begin
      #1;
      if (blk_chk && wb_p && rd_p) begin
        chk("rd_ready_blocked_by_wb", blk_t'(rd_ready), blk_t'(0));
        blk_chk = 0;
      end
      if (wb_p && wb_ready) begin
        q0.push_back('{1'b0, wdata, cyc + 1 + LAT0});
        wb_p = 0;
      end else if (rd_p && rd_ready) begin
        q0.push_back('{1'b1, rexp, cyc + 1 + LAT0});
        rd_p = 0;
      end
      @(negedge clk);
      budget++;
      if (!wb_p) wb_valid = 1'b0;
      if (!rd_p) rd_req = 1'b0;
    end
    if (wb_p || rd_p) begin
      chk("dut0_accept_timeout", blk_t'(1), blk_t'(0));
      wb_valid = 1'b0; rd_req = 1'b0;
    end
  endtask

  // dut1 single request; caller must be at a negedge, returns at a negedge.
  task automatic op1(input bit is_rd, input logic [31:0] addr, input blk_t d, output int acc);
    bit done = 0;
    int budget = 0;
    acc = -1;
    if (is_rd) begin rd_req1 = 1'b1; rd_addr1 = addr; end
    else begin wb_valid1 = 1'b1; wb_addr1 = addr; wb_data1 = d; end
    while (!done && budget < 20) begin
      #1;
      if (is_rd ? rd_ready1 : wb_ready1) begin
        acc = cyc + 1;
        q1.push_back('{is_rd, d, cyc + 1 + LAT1});
        done = 1;
      end else begin
        chk("dut1_busy_between", blk_t'(busy1), blk_t'(1));
      end
      @(negedge clk);
      budget++;
    end
    rd_req1 = 1'b0; wb_valid1 = 1'b0;
    if (!done) chk("dut1_accept_timeout", blk_t'(1), blk_t'(0));
  endtask

  task automatic drain();
    int budget = 0;
    while ((q0.size() != 0 || q1.size() != 0) && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    chk("drain_outstanding", blk_t'(q0.size() + q1.size()), blk_t'(0));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rd_valid"}, blk_t'(rd_valid), blk_t'(0));
    chk({tag, "_wb_done"}, blk_t'(wb_done), blk_t'(0));
    chk({tag, "_rd_data"}, rd_data, blk_t'(0));
    chk({tag, "_busy"}, blk_t'(busy), blk_t'(0));
    chk({tag, "_wb_ready"}, blk_t'(wb_ready), blk_t'(1));
    chk({tag, "_rd_ready"}, blk_t'(rd_ready), blk_t'(1));
  endtask

  initial begin
    int a1, a2, p;
    reset = 1'b1;
    wb_valid = 0; wb_addr = 0; wb_data = 0; rd_req = 0; rd_addr = 0;
    wb_valid1 = 0; wb_addr1 = 0; wb_data1 = 0; rd_req1 = 0; rd_addr1 = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk_idle("reset");
    chk("reset_dut1_busy", blk_t'(busy1), blk_t'(0));
    chk("reset_dut1_rd_data", rd_data1, blk_t'(0));

    // Writeback then read back the same block.
    xact(1, 32'h0000_0040, mk_block(32'hA5A5_0000), 0, 0, 0, 0);
    drain();
    xact(0, 0, 0, 1, 32'h0000_0040, mk_block(32'hA5A5_0000), 0);
    drain();

    // Old block at 0x80, then simultaneous new writeback and refill.
    xact(1, 32'h0000_0080, mk_block(32'h1111_0000), 0, 0, 0, 0);
    drain();
    xact(1, 32'h0000_0080, mk_block(32'h2222_0000), 1, 32'h0000_0080, mk_block(32'h2222_0000), 1);
    drain();

    // Aliasing: upper address bits ignored; a different index differs.
    xact(0, 0, 0, 1, 32'h0001_0040, mk_block(32'hA5A5_0000), 0);
    drain();
    xact(0, 0, 0, 1, 32'h0000_0080, mk_block(32'h2222_0000), 0);
    drain();

    // Reset two cycles into a writeback: it must be discarded.
    p = pulses0;
    @(negedge clk);
    wb_valid = 1'b1; wb_addr = 32'h0000_0040;
    wb_data = {16{32'hDEAD_BEEF}};
    #1;
    chk("abort_wb_ready", blk_t'(wb_ready), blk_t'(1));
    @(negedge clk);
    wb_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_idle("abort");
    repeat (LAT0 + 2) @(negedge clk);
    chk("abort_no_wb_done", blk_t'(pulses0), blk_t'(p));
    xact(0, 0, 0, 1, 32'h0000_0040, mk_block(32'hA5A5_0000), 0);
    drain();

    // LATENCY=1 instance: two writes, then back-to-back reads.
    @(negedge clk);
    op1(0, 32'h0000_0040, mk_block(32'h3333_0000), a1);
    op1(0, 32'h0000_00C0, mk_block(32'h4444_0000), a2);
    drain();
    op1(1, 32'h0000_0040, mk_block(32'h3333_0000), a1);
    op1(1, 32'h0000_00C0, mk_block(32'h4444_0000), a2);
    chk("dut1_accept_spacing", blk_t'(a2 - a1), blk_t'(3));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
